pc_fetch_ctrl: RTL and testbench

//   Owns the architectural PC and sequences instruction fetch for the CPU front end.

---
 rtl/pc_fetch_ctrl.sv | 133 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Front-end fetch sequencer: owns the architectural PC, runs the req/ack fetch to
// instruction memory, holds the fetched word for decode and applies exception redirects.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        rstn,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   input  logic        if_ready,
   input  logic        jump,
   input  logic        branch,
   input  logic [25:0] imm26,
   input  logic        exc_req,
   output logic [31:0] pc_o,
   output logic [31:0] pcplus4_o,
   output logic [31:0] epc_o
);

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_VALID = 2'd3;

   // Op 2'b11 is illegal and deliberately falls through to the sequential path.
   function automatic logic [31:0] calc_npc(input logic [31:0] p4,
                                            input logic [1:0]  op,
                                            input logic [25:0] imm);
      case (op)
         2'b01:   calc_npc = p4 + {{14{imm[15]}}, imm[15:0], 2'b00};
         2'b10:   calc_npc = {p4[31:28], imm, 2'b00};
         default: calc_npc = p4;
      endcase
   endfunction

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] epc_q, epc_d;
   logic        req_q, valid_q;
   logic [31:0] pcplus4_s;
   logic        handshake_s;

   assign pcplus4_s   = pc_q + 32'd4;
   assign handshake_s = valid_q & if_ready;

   // Next-state, PC, held-instruction and EPC selection.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      epc_d   = epc_q;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (exc_req) begin
               epc_d   = pc_q;
               pc_d    = EXC_VECTOR;
               // An un-acked request is still owed a response, so it must be drained.
               state_d = imem_ack ? ST_FETCH : ST_DRAIN;
            end else if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = ST_VALID;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_DRAIN: begin
            if (exc_req) begin
               epc_d = pc_q;
               pc_d  = EXC_VECTOR;
            end else begin
               pc_d = pc_q;
            end
            if (imem_ack) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_VALID: begin
            if (exc_req) begin
               epc_d   = pc_q;
               pc_d    = EXC_VECTOR;
               state_d = ST_FETCH;
            end else if (handshake_s) begin
               pc_d    = calc_npc(pcplus4_s, {jump, branch}, imm26);
               state_d = ST_FETCH;
            end else begin
               state_d = ST_VALID;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // State and datapath registers; req/valid are registered decodes of the next state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0000_0000;
         epc_q   <= 32'h0000_0000;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         epc_q   <= epc_d;
         req_q   <= (state_d == ST_FETCH);
         valid_q <= (state_d == ST_VALID);
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = pc_q;
   assign if_valid  = valid_q;
   assign if_instr  = instr_q;
   assign pc_o      = pc_q;
   assign pcplus4_o = pcplus4_s;
   assign epc_o     = epc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: a driver plays decode and instruction memory while
// a behavioural model queues the expected fetches/handshakes that a monitor checks.
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic        if_ready;
   logic        jump;
   logic        branch;
   logic [25:0] imm26;
   logic        exc_req;
   logic [31:0] pc_o;
   logic [31:0] pcplus4_o;
   logic [31:0] epc_o;

   pc_fetch_ctrl dut (
      .clk        (clk),
      .rstn       (rstn),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .if_valid   (if_valid),
      .if_instr   (if_instr),
      .if_ready   (if_ready),
      .jump       (jump),
      .branch     (branch),
      .imm26      (imm26),
      .exc_req    (exc_req),
      .pc_o       (pc_o),
      .pcplus4_o  (pcplus4_o),
      .epc_o      (epc_o)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] EXC_VEC   = 32'h0000_4180;
   localparam logic [31:0] DRAIN_WORD = 32'hBAD0_BAD0;

   typedef struct { bit req; bit valid; } cyc_exp_t;
   typedef struct { bit req; logic [31:0] addr; } fetch_exp_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; logic [31:0] epc; } hs_exp_t;

   cyc_exp_t   cyc_q[$];
   fetch_exp_t fetch_q[$];
   hs_exp_t    hs_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   bit run_mon  = 1'b0;

   // Reference model: abstract fetch pipeline bookkeeping.
   bit          m_boot, m_hold, m_drain;
   logic [31:0] m_pc, m_epc, m_instr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] ref_next_pc(input logic [31:0] pc, input bit j,
                                               input bit b, input logic [25:0] imm);
      logic [31:0] p4;
      int          off;
      p4  = pc + 32'd4;
      off = $signed(imm[15:0]);
      if (!j && b)      return p4 + 32'(off * 4);
      else if (j && !b) return (p4 & 32'hF000_0000) | (32'(imm) << 2);
      else              return p4;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the model predicts what the upcoming edge must do.
   task automatic cycle(input bit ack, input bit rdy, input bit j, input bit b,
                        input logic [25:0] imm, input bit exc);
      bit fetching;
      fetching   = !m_boot && !m_hold && !m_drain;
      imem_ack   = ack;
      imem_rdata = m_drain ? DRAIN_WORD : mem_word(imem_addr);
      if_ready   = rdy;
      jump       = j;
      branch     = b;
      imm26      = imm;
      exc_req    = exc;
      cyc_q.push_back('{req: fetching, valid: m_hold});
      if (m_boot) begin
         m_boot = 1'b0;
      end else if (fetching) begin
         if (ack) fetch_q.push_back('{req: 1'b1, addr: m_pc});
         if (exc) begin
            m_epc   = m_pc;
            m_pc    = EXC_VEC;
            m_drain = !ack;
         end else if (ack) begin
            m_instr = mem_word(m_pc);
            m_hold  = 1'b1;
         end
      end else if (m_drain) begin
         if (ack) begin
            fetch_q.push_back('{req: 1'b0, addr: 32'h0});
            m_drain = 1'b0;
         end
         if (exc) begin
            m_epc = m_pc;
            m_pc  = EXC_VEC;
         end
      end else begin
         if (exc) begin
            m_epc  = m_pc;
            m_pc   = EXC_VEC;
            m_hold = 1'b0;
         end else if (rdy) begin
            hs_q.push_back('{pc: m_pc, instr: m_instr, epc: m_epc});
            m_pc   = ref_next_pc(m_pc, j, b, imm);
            m_hold = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input bit j, input bit b, input logic [25:0] imm);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 26'h0, 1'b0);
      cycle(1'b0, 1'b1, j, b, imm, 1'b0);
   endtask

   // Monitor: compares DUT activity against the queued expectations mid-cycle.
   always @(negedge clk) begin
      if (rstn && run_mon) begin
         if (cyc_q.size() == 0) begin
            chk("cycle_expectation_present", 32'd0, 32'd1);
         end else begin
            cyc_exp_t c;
            c = cyc_q.pop_front();
            chk("imem_req", 32'(imem_req), 32'(c.req));
            chk("if_valid", 32'(if_valid), 32'(c.valid));
         end
         if (imem_ack) begin
            if (fetch_q.size() == 0) begin
               chk("fetch_expected", 32'd0, 32'd1);
            end else begin
               fetch_exp_t f;
               f = fetch_q.pop_front();
               chk("ack_with_req", 32'(imem_req), 32'(f.req));
               if (f.req) chk("fetch_addr", imem_addr, f.addr);
            end
         end
         if (if_valid && if_ready && !exc_req) begin
            if (hs_q.size() == 0) begin
               chk("handshake_expected", 32'd0, 32'd1);
            end else begin
               hs_exp_t h;
               h = hs_q.pop_front();
               chk("hs_pc", pc_o, h.pc);
               chk("hs_instr", if_instr, h.instr);
               chk("hs_epc", epc_o, h.epc);
               chk("hs_pcplus4", pcplus4_o, h.pc + 32'd4);
            end
         end
      end
   end

   initial begin
      logic [31:0] held_instr;
      rstn = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; if_ready = 1'b0;
      jump = 1'b0; branch = 1'b0; imm26 = 26'h0; exc_req = 1'b0;
      m_boot = 1'b1; m_hold = 1'b0; m_drain = 1'b0;
      m_pc = 32'h0000_3000; m_epc = 32'h0; m_instr = 32'h0;
      #12;
      chk("rst_pc", pc_o, 32'h0000_3000);
      chk("rst_pcplus4", pcplus4_o, 32'h0000_3004);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_instr", if_instr, 32'h0);
      chk("rst_epc", epc_o, 32'h0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      run_mon = 1'b1;

      // Sequential fetch with zero-wait memory.
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 26'h0, 1'b0);
      chk("first_fetch_addr", imem_addr, 32'h0000_3000);
      chk("first_fetch_req", 32'(imem_req), 32'd1);
      repeat (3) issue(1'b0, 1'b0, 26'h0);
      chk("seq_pc", pc_o, 32'h0000_300C);
      issue(1'b0, 1'b0, 26'h0);
      chk("seq_pc2", pc_o, 32'h0000_3010);

      // Branches and jumps.
      issue(1'b0, 1'b1, 26'h000_FFFE);
      chk("branch_back", pc_o, 32'h0000_300C);
      issue(1'b0, 1'b1, 26'h000_0004);
      chk("branch_fwd", pc_o, 32'h0000_3020);
      issue(1'b1, 1'b0, 26'h000_0C04);
      chk("jump_3010", pc_o, 32'h0000_3010);
      issue(1'b1, 1'b0, 26'h000_0C40);
      chk("jump_3100", pc_o, 32'h0000_3100);
      issue(1'b1, 1'b0, 26'h000_0C04);
      issue(1'b1, 1'b1, 26'h3FF_FFFF);
      chk("illegal_op", pc_o, 32'h0000_3014);

      // Decode stall.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 26'h0, 1'b0);
      held_instr = mem_word(32'h0000_3014);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b0, 1'b1, 1'b0, 26'h3FF_FFFF, 1'b0);
         chk("stall_instr", if_instr, held_instr);
         chk("stall_pc", pc_o, 32'h0000_3014);
         chk("stall_req", 32'(imem_req), 32'd0);
      end
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 26'h0, 1'b0);
      chk("stall_release_pc", pc_o, 32'h0000_3018);
      chk("stall_release_valid", 32'(if_valid), 32'd0);

      // Exception while a fetch is outstanding.
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 26'h0, 1'b1);
      chk("drain_epc", epc_o, 32'h0000_3018);
      chk("drain_pc", pc_o, EXC_VEC);
      chk("drain_req", 32'(imem_req), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 26'h0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 26'h0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 26'h0, 1'b0);
      chk("post_drain_addr", imem_addr, EXC_VEC);
      chk("post_drain_req", 32'(imem_req), 32'd1);
      issue(1'b0, 1'b0, 26'h0);

      // Exception beats a simultaneous jump handshake.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 26'h0, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 26'h155_5555, 1'b1);
      chk("exc_hs_pc", pc_o, EXC_VEC);
      chk("exc_hs_epc", epc_o, 32'h0000_4184);
      chk("exc_hs_valid", 32'(if_valid), 32'd0);

      // Randomised traffic.
      for (int i = 0; i < 600; i++) begin
         bit can_ack;
         can_ack = !m_boot && !m_hold;
         cycle(can_ack && ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               26'($urandom), $urandom_range(0, 9) == 0);
      end
      run_mon = 1'b0;
      chk("cyc_q_empty", 32'(cyc_q.size()), 32'd0);
      chk("fetch_q_empty", 32'(fetch_q.size()), 32'd0);
      chk("hs_q_empty", 32'(hs_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
